// File: rtl/pc_redirect_ctrl.sv
// Fetch program counter with redirects from ID (jump / register jump) and EX (branch).
// Redirects that arrive during a stall are held until the stall clears.
module pc_redirect_ctrl #(
    parameter int                 PC_SIZE  = 32,
    parameter int                 PC_STEP  = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0,
    parameter int                 CNT_SIZE = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_halt,
    input  logic                i_stall,
    input  logic                i_jump_valid,
    input  logic [PC_SIZE-1:0]  i_jump_addr,
    input  logic                i_jr_valid,
    input  logic [PC_SIZE-1:0]  i_jr_addr,
    input  logic                i_branch_taken,
    input  logic [PC_SIZE-1:0]  i_branch_addr,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic [PC_SIZE-1:0]  o_pc_plus4,
    output logic                o_flush,
    output logic                o_misaligned,
    output logic                o_halted,
    output logic [CNT_SIZE-1:0] o_redirect_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state;
    logic [PC_SIZE-1:0]   pc;
    logic                 flush_q;
    logic                 misaligned_q;
    logic [CNT_SIZE-1:0]  cnt;
    logic                 pend_valid;
    logic [PC_SIZE-1:0]   pend_addr;
    logic [1:0]           pend_rank;

    logic                 new_valid;
    logic [PC_SIZE-1:0]   new_addr;
    logic [1:0]           new_rank;
    logic                 apply;
    logic [PC_SIZE-1:0]   target;

    // Rank encodes age: the EX branch is the oldest instruction and wins.
    always_comb begin
        new_valid = 1'b1;
        new_addr  = '0;
        new_rank  = 2'd0;
        if (i_branch_taken) begin
            new_addr = i_branch_addr;
            new_rank = 2'd3;
        end else if (i_jump_valid) begin
            new_addr = i_jump_addr;
            new_rank = 2'd2;
        end else if (i_jr_valid) begin
            new_addr = i_jr_addr;
            new_rank = 2'd1;
        end else begin
            new_valid = 1'b0;
        end
    end

    always_comb begin
        apply  = (state == RUN) && !i_stall && (new_valid || pend_valid);
        target = new_valid ? new_addr : pend_addr;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
            cnt          <= '0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_rank    <= 2'd0;
        end else if (i_enable) begin
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) state <= RUN;
                end
                RUN: begin
                    if (apply) begin
                        pc           <= {target[PC_SIZE-1:2], 2'b00};
                        flush_q      <= 1'b1;
                        misaligned_q <= |target[1:0];
                        pend_valid   <= 1'b0;
                        if (cnt != '1) cnt <= cnt + 1'b1;
                    end else if (i_stall) begin
                        if (new_valid && (!pend_valid || new_rank >= pend_rank)) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= new_addr;
                            pend_rank  <= new_rank;
                        end
                        if (i_halt && !new_valid) state <= HALT;
                    end else if (i_halt) begin
                        state <= HALT;
                    end else begin
                        pc <= pc + PC_SIZE'(PC_STEP);
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_pc           = pc;
    assign o_pc_plus4     = pc + PC_SIZE'(PC_STEP);
    assign o_flush        = flush_q & i_enable;
    assign o_misaligned   = misaligned_q & i_enable;
    assign o_halted       = (state == HALT);
    assign o_redirect_cnt = cnt;

endmodule
